alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational yAlu32 between N requesters (e.g. fetch PC-increment, branch-target, datapath EX).
//  Round-robin arbitration, operand capture, one-op-at-a-time sequencing, registered result with response handshake.
//  Sits between the requesting units and the single ALU instance; the ALU itself is instantiated outside this block.
// PARAMETERS
//  N   4   number of requesters (2..8)
//  W   32  operand/result width; must match the ALU
//  IW  2   requester-id width, = clog2(N)
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst        in   1     asynchronous, active-high reset
//  req_valid  in   N     requester i has an op pending
//  req_ready  out  N     one-hot; op of requester i accepted this cycle
//  req_a      in   N*W   operand a, requester i at [i*W +: W]
//  req_b      in   N*W   operand b, same packing
//  req_op     in   N*3   ALU opcode, requester i at [i*3 +: 3]
//  rsp_valid  out  1     result available
//  rsp_ready  in   1     consumer takes result
//  rsp_id     out  IW    requester that issued the op
//  rsp_z      out  W     registered ALU result
//  rsp_ex     out  1     registered ALU ex (zero) flag
//  alu_a      out  W     to ALU a
//  alu_b      out  W     to ALU b
//  alu_op     out  3     to ALU op
//  alu_z      in   W     from ALU z
//  alu_ex     in   1     from ALU ex
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_z=0, rsp_ex=0, operand regs/alu_*=0.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: if any req_valid, grant = first set bit scanning from pointer upward (mod N); req_ready[grant]=1
//         combinationally this cycle; capture a/b/op/id into regs; pointer <= grant+1 mod N; -> EXEC.
//         No req_valid: stay, req_ready=0.
//   EXEC: alu_* driven from operand regs (alu_* always = regs, never from req_* directly);
//         end of cycle rsp_z<=alu_z, rsp_ex<=alu_ex, rsp_valid<=1; -> RESP.
//   RESP: rsp_valid held, rsp_* stable until rsp_valid&rsp_ready; then rsp_valid<=0, -> IDLE.
//  req_ready is 0 in EXEC and RESP; at most one bit set, only in IDLE.
//  Latency: accept at cycle T, rsp_valid high from T+2; peak throughput 1 op / 3 cycles.
//  Requester must hold req_* stable until its req_ready; dropping req_valid before grant is legal (no grant).
//  Opcode passed through unchecked (000 and, 001 or, 010 add, 110 sub, 111 slt); unused codes give whatever the ALU gives.
//  Arithmetic is entirely in the ALU; this block does no width extension or overflow handling.
//  Reset mid-operation: any in-flight op is discarded, no response issued, pointer returns to 0.
//  Same requester re-requesting is served again only after all other pending requesters (fairness bound N-1 ops).
// STRUCTURE
//  Package alu_share_pkg: ALU opcode localparams (OP_AND/OR/ADD/SUB/SLT), FSM state encoding (S_IDLE/S_EXEC/S_RESP).
//  One sub-module: rr_arbiter (N req in, pointer in, one-hot grant + encoded id out, combinational).
//  Top holds FSM, pointer, operand/result registers and response handshake.
// TESTING (bench instantiates real yAlu32 behind the arbiter)
//  1 Reset: rst=1 mid-EXEC of op a=5,b=3,op=010 -> rsp_valid stays 0, req_ready=0, after release pointer=0.
//  2 Single op: req 0 a=7,b=5,op=010 at T -> req_ready=0001 at T, rsp_valid at T+2, rsp_z=12, rsp_ex=0, rsp_id=0.
//  3 Sub/zero: req 2 a=-42,b=-42,op=110 -> rsp_z=0, rsp_ex=1, rsp_id=2.
//  4 Fairness: all 4 req_valid held, rsp_ready=1 -> grant order 0,1,2,3,0 with ops every 3 cycles.
//  5 Backpressure: rsp_ready=0 for 5 cycles with req 1 a=3,b=9,op=111 -> rsp_z=1 stable, no new req_ready until taken.
//  6 Random: 200 ops, random a,b in [-99,99], ops {000,001,010,110,111}, random rsp_ready -> compare to golden model.

Source files
------------

// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - opcodes and FSM encoding shared by the ALU arbiter slice
package alu_share_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester and response bundle of the ALU arbiter
interface alu_share_arbiter_if #(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int IW = 2
);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*3-1:0] req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_z;
  logic           rsp_ex;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_ex
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_z, rsp_ex
  );
endinterface

// File: rtl/alu_share_arbiter_rr.sv
// rtl/alu_share_arbiter_rr.sv - round-robin pick: first request at or above the pointer, wrapping
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] id_o,
  output logic          any_o
);
  logic [IW-1:0] idx;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        id_o         = idx;
        any_o        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/yalu32.sv
// rtl/yalu32.sv - combinational 32-bit ALU shared through alu_share_arbiter
module yAlu32
  import alu_share_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  output logic [31:0] z_o,
  output logic        ex_o
);
  always_comb begin
    case (op_i)
      OP_AND:  z_o = a_i & b_i;
      OP_OR:   z_o = a_i | b_i;
      OP_ADD:  z_o = a_i + b_i;
      OP_SUB:  z_o = a_i - b_i;
      OP_SLT:  z_o = {31'b0, $signed(a_i) < $signed(b_i)};
      default: z_o = '0;
    endcase
  end

  assign ex_o = (z_o == '0);
endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one ALU among N requesters, one op at a time
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int IW = 2
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus,
  output logic [W-1:0]        alu_a_o,
  output logic [W-1:0]        alu_b_o,
  output logic [2:0]          alu_op_o,
  input  logic [W-1:0]        alu_z_i,
  input  logic                alu_ex_i
);
  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, id_q, id_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, z_q, z_d;
  logic [2:0]    op_q, op_d;
  logic          ex_q, ex_d, rv_q, rv_d;

  logic [N-1:0]  arb_grant;
  logic [IW-1:0] arb_id;
  logic          arb_any;

  rr_arbiter #(.N(N), .IW(IW)) u_rr (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .id_o    (arb_id),
    .any_o   (arb_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arb_any) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == S_IDLE) ? arb_grant : '0;
  end

  // Operands are latched at grant so the ALU never sees req_* change mid-op.
  always_comb begin
    ptr_d = ptr_q;
    id_d  = id_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    z_d   = z_q;
    ex_d  = ex_q;
    rv_d  = rv_q;
    case (state_q)
      S_IDLE: if (arb_any) begin
        a_d   = bus.req_a[arb_id*W +: W];
        b_d   = bus.req_b[arb_id*W +: W];
        op_d  = bus.req_op[arb_id*3 +: 3];
        id_d  = arb_id;
        ptr_d = (int'(arb_id) == N-1) ? '0 : arb_id + 1'b1;
      end
      S_EXEC: begin
        z_d  = alu_z_i;
        ex_d = alu_ex_i;
        rv_d = 1'b1;
      end
      S_RESP: if (bus.rsp_ready) rv_d = 1'b0;
      default: rv_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      id_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      z_q   <= '0;
      ex_q  <= 1'b0;
      rv_q  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      id_q  <= id_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      z_q   <= z_d;
      ex_q  <= ex_d;
      rv_q  <= rv_d;
    end
  end

  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  assign alu_op_o      = op_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_z     = z_q;
  assign bus.rsp_ex    = ex_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - arbiter plus real yAlu32 against a transaction-level model
module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.N(N), .W(W), .IW(IW)) bus ();

  logic [W-1:0] alu_a, alu_b, alu_z;
  logic [2:0]   alu_op;
  logic         alu_ex;

  alu_share_arbiter #(.N(N), .W(W), .IW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_a_o  (alu_a),
    .alu_b_o  (alu_b),
    .alu_op_o (alu_op),
    .alu_z_i  (alu_z),
    .alu_ex_i (alu_ex)
  );

  yAlu32 u_alu (
    .a_i  (alu_a),
    .b_i  (alu_b),
    .op_i (alu_op),
    .z_o  (alu_z),
    .ex_o (alu_ex)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, req);
    end
  endtask

  function automatic logic [31:0] golden(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return 32'(sa + sb);
      3'b110:  return 32'(sa - sb);
      3'b111:  return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Model: a granted op occupies the ALU; its result is visible two cycles after grant.
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  int          m_ptr  = 0;
  int          m_id   = 0;
  int          m_done = 0;
  logic [31:0] m_a = '0, m_b = '0, m_z = '0;
  logic [2:0]  m_op = '0;
  bit          m_ex = 1'b0;

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int g, idx;
    if (rst) begin
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_op", alu_op, 0);
      m_busy = 1'b0; m_age = 0; m_ptr = 0;
      m_a = '0; m_b = '0; m_op = '0;
    end else begin
      exp_rdy = '0;
      g = -1;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && bus.req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", bus.req_ready, exp_rdy);
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      check("alu_op", alu_op, m_op);
      check("rsp_valid", bus.rsp_valid, (m_busy && m_age >= 2));
      if (m_busy && m_age >= 2) begin
        check("rsp_z", bus.rsp_z, m_z);
        check("rsp_ex", bus.rsp_ex, m_ex);
        check("rsp_id", bus.rsp_id, m_id);
      end
      if (m_busy) begin
        if (m_age >= 2 && bus.rsp_ready) begin
          m_busy = 1'b0;
          m_done++;
        end else begin
          m_age++;
        end
      end else if (g >= 0) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_ptr  = (g + 1) % N;
        m_id   = g;
        m_a    = bus.req_a[g*W +: W];
        m_b    = bus.req_b[g*W +: W];
        m_op   = bus.req_op[g*3 +: 3];
        m_z    = golden(m_a, m_b, m_op);
        m_ex   = (m_z == 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, int a, int b, logic [2:0] op);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_op[i*3 +: 3] = op;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic rand_req(int i);
    logic [2:0] ops [5];
    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    set_req(i, int'($urandom_range(198)) - 99, int'($urandom_range(198)) - 99,
            ops[$urandom_range(4)]);
  endtask

  int gcyc[$];
  int gidx[$];

  initial begin
    logic [N-1:0] gnt;
    int base, cycles;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_rsp_z", bus.rsp_z, 0);
    check("reset_rsp_id", bus.rsp_id, 0);
    check("reset_rsp_ex", bus.rsp_ex, 0);

    // single add from requester 0
    tick();
    bus.rsp_ready = 1'b1;
    set_req(0, 7, 5, OP_ADD);
    @(negedge clk);
    check("single_ready_T", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("single_valid_T1", bus.rsp_valid, 0);
    @(negedge clk);
    check("single_valid_T2", bus.rsp_valid, 1);
    check("single_z", bus.rsp_z, 12);
    check("single_ex", bus.rsp_ex, 0);
    check("single_id", bus.rsp_id, 0);

    // subtract to zero from requester 2
    tick();
    set_req(2, -42, -42, OP_SUB);
    @(negedge clk);
    check("sub_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("sub_z", bus.rsp_z, 0);
    check("sub_ex", bus.rsp_ex, 1);
    check("sub_id", bus.rsp_id, 2);

    // reset during EXEC discards the op
    tick();
    set_req(1, 5, 3, OP_ADD);
    @(negedge clk);
    check("rst_op_ready", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_no_rsp", bus.rsp_valid, 0);
    end

    // fairness with all four requesters held; pointer must restart at 0
    tick();
    for (int i = 0; i < N; i++) set_req(i, 10 + i, 1, OP_ADD);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[i]) begin
          gcyc.push_back(c);
          gidx.push_back(i);
        end
      end
    end
    tick();
    bus.req_valid = '0;
    check("fair_grants", gcyc.size(), 5);
    for (int j = 0; j < 5; j++) begin
      if (j < gcyc.size()) begin
        check("fair_cycle", gcyc[j], 3 * j);
        check("fair_id", gidx[j], j % 4);
      end
    end
    repeat (4) @(negedge clk);

    // backpressure on an slt result while another requester waits
    tick();
    bus.rsp_ready = 1'b0;
    set_req(1, 3, 9, OP_SLT);
    @(negedge clk);
    check("bp_ready", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid[1] = 1'b0;
    set_req(3, 4, 4, OP_OR);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_z", bus.rsp_z, 1);
      check("bp_ex", bus.rsp_ex, 0);
      check("bp_id", bus.rsp_id, 1);
      check("bp_no_grant", bus.req_ready, 0);
    end
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_held_until_taken", bus.rsp_valid, 1);
    @(negedge clk);
    check("bp_next_grant", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = '0;
    repeat (4) @(negedge clk);

    // random traffic: 200 ops with random consumer backpressure
    base   = m_done;
    cycles = 0;
    gnt    = '0;
    while (m_done < base + 200 && cycles < 20000) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          bus.req_valid[i] = 1'b0;
          if ($urandom_range(1) == 1) rand_req(i);
        end else if (!bus.req_valid[i]) begin
          if ($urandom_range(2) == 0) rand_req(i);
        end else if ($urandom_range(15) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom_range(1) == 1);
      @(negedge clk);
      gnt = bus.req_ready;
      cycles++;
    end
    check("random_ops_done", (m_done >= base + 200), 1);

    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
